split_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 288-bit-to-32-bit word serializer between N_REQ convolution engines.
- Each engine presents a nine-word (3x3) bundle of IEEE-754 single-precision results.
- The block grants one bundle at a time, captures it, and streams it out MSB-word first over a valid/ready interface, tagged with source ID and last flag.
- Sits between the conv engine array and the downstream reconstruction/writeback stage.

---
 rtl/split_arbiter_if.sv | 32 +++
 rtl/split_arbiter.sv | 118 +++++++++++
 tb/tb_split_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_arbiter_if.sv
// Request/stream bundle between the conv engine array, the split arbiter and the
// downstream writeback stage.
interface split_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int WORDS  = 9,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  localparam int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BUNDLE_W = WORDS * WORD_W;

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*BUNDLE_W-1:0] req_data;
  logic [N_REQ-1:0]          req_ack;
  logic [WORD_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic [SRC_W-1:0]          out_src;
  logic                      busy;
  logic [CNT_W-1:0]          bundle_cnt;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ack, out_data, out_valid, out_last, out_src, busy, bundle_cnt
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ack, out_data, out_valid, out_last, out_src, busy, bundle_cnt
  );
endinterface

// File: rtl/split_arbiter.sv
// Round-robin arbiter that captures one multi-word bundle at a time from N_REQ
// engines and streams it out MSB word first over valid/ready.
//
// state  | meaning
// S_IDLE | no bundle held; arbitrate among req_valid each cycle
// S_SEND | shadow bundle streaming; req_valid ignored until the last word
module split_arbiter #(
  parameter int N_REQ  = 2,
  parameter int WORDS  = 9,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  split_arbiter_if.slave bus
);
  localparam int BUNDLE_W = WORDS * WORD_W;
  localparam int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              r_state;
  logic [BUNDLE_W-1:0] r_shadow;
  logic [IDX_W-1:0]    r_idx;
  logic [SRC_W-1:0]    r_rr;
  logic [SRC_W-1:0]    r_src;
  logic [N_REQ-1:0]    r_ack;
  logic [WORD_W-1:0]   r_data;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_found;
  logic [SRC_W-1:0]    w_winner;
  logic [SRC_W-1:0]    w_cand;
  logic [BUNDLE_W-1:0] w_win_bundle;
  logic                w_last_word;

  // Scan from farthest to nearest so the candidate right after r_rr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = SRC_W'((int'(r_rr) + k) % N_REQ);
      if (bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_win_bundle = bus.req_data[int'(w_winner)*BUNDLE_W +: BUNDLE_W];
  assign w_last_word  = (r_idx == IDX_W'(WORDS-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_rr     <= SRC_W'(N_REQ-1);
      r_src    <= '0;
      r_ack    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            // Word 0 goes straight out; the shadow keeps the rest left-aligned.
            r_shadow <= w_win_bundle << WORD_W;
            r_data   <= w_win_bundle[BUNDLE_W-1 -: WORD_W];
            r_rr     <= w_winner;
            r_src    <= w_winner;
            r_ack    <= N_REQ'(1) << w_winner;
            r_valid  <= 1'b1;
            r_last   <= (WORDS == 1);
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.out_ready) begin
            if (w_last_word) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_cnt   <= r_cnt + 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_data   <= r_shadow[BUNDLE_W-1 -: WORD_W];
              r_shadow <= r_shadow << WORD_W;
              r_last   <= (r_idx == IDX_W'(WORDS-2));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ack    = r_ack;
  assign bus.out_data   = r_data;
  assign bus.out_valid  = r_valid;
  assign bus.out_last   = r_last;
  assign bus.out_src    = r_src;
  assign bus.busy       = r_busy;
  assign bus.bundle_cnt = r_cnt;
endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: directed and randomized bundles checked against a
// grant/word-order reference model.
module tb_split_arbiter;
  localparam int N_REQ  = 3;
  localparam int WORDS  = 9;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;
  localparam int BW     = WORDS * WORD_W;
  localparam int SW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic clk;
  logic reset;

  split_arbiter_if #(.N_REQ(N_REQ), .WORDS(WORDS), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_if ();

  split_arbiter #(.N_REQ(N_REQ), .WORDS(WORDS), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: last granted requester and completed-bundle count
  int m_last = N_REQ - 1;
  int m_cnt  = 0;

  // observations from the most recent collected bundle
  logic [WORD_W-1:0] obs_q[$];
  int                obs_wait, obs_start, obs_last_bad, obs_stable_bad, obs_busy_bad, obs_valid_bad;
  bit                obs_timeout;
  logic [N_REQ-1:0]  obs_ack0, obs_ack1;
  logic [SW-1:0]     obs_src;
  logic              obs_after_valid, obs_after_busy;
  logic [CNT_W-1:0]  obs_after_cnt;

  function automatic logic [BW-1:0] rand_bundle();
    logic [BW-1:0] b;
    for (int k = 0; k < WORDS; k++) b[k*WORD_W +: WORD_W] = $urandom();
    return b;
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [BW-1:0] b, input int k);
    logic [BW-1:0] t;
    t = b >> (WORD_W * (WORDS - 1 - k));
    return t[WORD_W-1:0];
  endfunction

  function automatic int pick(input logic [N_REQ-1:0] m, input int last);
    for (int off = 1; off <= N_REQ; off++)
      if (m[(last + off) % N_REQ]) return (last + off) % N_REQ;
    return -1;
  endfunction

  function automatic int word_errs(input logic [BW-1:0] exp);
    int e;
    e = (obs_q.size() != WORDS) ? 1 : 0;
    for (int k = 0; k < obs_q.size() && k < WORDS; k++)
      if (obs_q[k] !== word_of(exp, k)) e++;
    return e;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_bundle(input int i, input logic [BW-1:0] b);
    u_if.req_data[i*BW +: BW] = b;
  endtask

  // Waits for a bundle and records it. mode: 0 ready high, 1 random ready,
  // 2 ready pattern 1,0,0, 3 stall word 4 and overwrite requester 0's data.
  task automatic collect(input int mode, input bit drop_on_ack);
    int n, t, stall4;
    logic r, stall_prev, p_last, exp_last;
    logic [WORD_W-1:0] p_data;
    obs_q.delete();
    obs_timeout = 0; obs_last_bad = 0; obs_stable_bad = 0; obs_busy_bad = 0; obs_valid_bad = 0;
    obs_ack1 = '0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!u_if.out_valid && n < 40);
    if (!u_if.out_valid) begin
      obs_timeout = 1;
      return;
    end
    obs_wait = n; obs_start = cyc; obs_ack0 = u_if.req_ack; obs_src = u_if.out_src;
    if (drop_on_ack) u_if.req_valid = u_if.req_valid & ~u_if.req_ack;
    t = 0; stall4 = 0; stall_prev = 0; p_data = '0; p_last = 0;
    forever begin
      if (t > 0) begin
        @(posedge clk); #1;
        if (t == 1) obs_ack1 = u_if.req_ack;
      end
      if (t > 400) begin
        obs_timeout = 1;
        return;
      end
      if (!u_if.out_valid) obs_valid_bad++;
      if (!u_if.busy) obs_busy_bad++;
      if (u_if.out_src !== obs_src) obs_stable_bad++;
      if (stall_prev && (u_if.out_data !== p_data || u_if.out_last !== p_last)) obs_stable_bad++;
      exp_last = (obs_q.size() == WORDS - 1);
      if (u_if.out_last !== exp_last) obs_last_bad++;
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        2: r = (t % 3 == 0);
        default: begin
          r = !(obs_q.size() == 4 && stall4 < 3);
          if (!r) begin
            if (stall4 == 0) set_bundle(0, {WORDS{32'hdeadbeef}});
            stall4++;
          end
        end
      endcase
      u_if.out_ready = r;
      if (u_if.out_valid && r) obs_q.push_back(u_if.out_data);
      stall_prev = u_if.out_valid && !r;
      p_data = u_if.out_data;
      p_last = u_if.out_last;
      t++;
      if (obs_q.size() == WORDS) break;
    end
    @(posedge clk); #1;
    obs_after_valid = u_if.out_valid;
    obs_after_busy  = u_if.busy;
    obs_after_cnt   = u_if.bundle_cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.req_valid = '0; u_if.req_data = '0; u_if.out_ready = 1'b0;
    #3 reset = 1'b0;
    #9;
    n_checks++; if (u_if.req_ack !== '0) begin n_errors++; $display("FAIL reset_ack: got %b want 0", u_if.req_ack); end
    n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", u_if.out_valid); end
    n_checks++; if (u_if.out_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b want 0", u_if.out_last); end
    n_checks++; if (u_if.out_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h want 0", u_if.out_data); end
    n_checks++; if (u_if.out_src !== '0) begin n_errors++; $display("FAIL reset_src: got %0d want 0", u_if.out_src); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
    n_checks++; if (u_if.bundle_cnt !== '0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", u_if.bundle_cnt); end
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_release_idle: got valid=%b busy=%b want 0 0", u_if.out_valid, u_if.busy);
    end
    m_last = N_REQ - 1; m_cnt = 0;
  endtask

  task automatic test_single_bundle();
    logic [BW-1:0] b;
    int exp;
    b = {32'h3f000000, 32'h3f100000, 32'h3f200000, 32'h3f300000, 32'h3f400000,
         32'h3f500000, 32'h3f600000, 32'h3f700000, 32'h3f800000};
    set_bundle(0, b);
    u_if.req_valid = 3'b001;
    u_if.out_ready = 1'b1;
    exp = pick(3'b001, m_last);
    collect(0, 1);
    m_last = exp; m_cnt = (m_cnt + 1) % (1 << CNT_W);
    n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL single_timeout: got timeout want bundle"); end
    n_checks++; if (obs_wait != 1) begin n_errors++; $display("FAIL single_latency: got %0d want 1", obs_wait); end
    n_checks++; if (obs_ack0 !== onehot(exp)) begin n_errors++; $display("FAIL single_ack: got %b want %b", obs_ack0, onehot(exp)); end
    n_checks++; if (obs_ack1 !== '0) begin n_errors++; $display("FAIL single_ack_pulse: got %b want 0", obs_ack1); end
    n_checks++; if (obs_src !== SW'(exp)) begin n_errors++; $display("FAIL single_src: got %0d want %0d", obs_src, exp); end
    n_checks++; if (word_errs(b) != 0) begin
      n_errors++; $display("FAIL single_words: got %0d bad words (first %h) want 0", word_errs(b), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
    end
    n_checks++; if (obs_last_bad != 0) begin n_errors++; $display("FAIL single_last: got %0d bad want 0", obs_last_bad); end
    n_checks++; if (obs_busy_bad != 0) begin n_errors++; $display("FAIL single_busy: got %0d low cycles want 0", obs_busy_bad); end
    n_checks++; if (obs_after_busy !== 1'b0 || obs_after_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_idle_after: got busy=%b valid=%b want 0 0", obs_after_busy, obs_after_valid);
    end
    n_checks++; if (obs_after_cnt !== CNT_W'(m_cnt)) begin n_errors++; $display("FAIL single_cnt: got %0d want %0d", obs_after_cnt, m_cnt); end
  endtask

  task automatic test_round_robin();
    logic [BW-1:0] b0, b1;
    int exp, prev_start;
    b0 = {WORDS{32'h11111111}};
    b1 = {WORDS{32'h22222222}};
    set_bundle(0, b0); set_bundle(1, b1);
    u_if.req_valid = 3'b011;
    u_if.out_ready = 1'b1;
    prev_start = 0;
    for (int i = 0; i < 4; i++) begin
      exp = pick(3'b011, m_last);
      collect(0, 0);
      m_last = exp; m_cnt = (m_cnt + 1) % (1 << CNT_W);
      n_checks++; if (obs_timeout || obs_src !== SW'(exp)) begin
        n_errors++; $display("FAIL rr_src[%0d]: got %0d (timeout=%0d) want %0d", i, obs_src, obs_timeout, exp);
      end
      n_checks++; if (word_errs(exp == 0 ? b0 : b1) != 0) begin
        n_errors++; $display("FAIL rr_words[%0d]: got %0d bad words want 0", i, word_errs(exp == 0 ? b0 : b1));
      end
      n_checks++; if (obs_ack0 !== onehot(exp)) begin n_errors++; $display("FAIL rr_ack[%0d]: got %b want %b", i, obs_ack0, onehot(exp)); end
      if (i > 0) begin
        n_checks++; if (obs_start - prev_start != WORDS + 1) begin
          n_errors++; $display("FAIL rr_period[%0d]: got %0d want %0d", i, obs_start - prev_start, WORDS + 1);
        end
      end
      n_checks++; if (obs_after_valid !== 1'b0) begin n_errors++; $display("FAIL rr_bubble[%0d]: got valid=%b want 0", i, obs_after_valid); end
      prev_start = obs_start;
    end
    u_if.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] b;
    int exp;
    b = rand_bundle();
    set_bundle(1, b);
    u_if.req_valid = 3'b010;
    exp = pick(3'b010, m_last);
    collect(2, 1);
    m_last = exp; m_cnt = (m_cnt + 1) % (1 << CNT_W);
    n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL bp_timeout: got timeout want bundle"); end
    n_checks++; if (obs_stable_bad != 0) begin n_errors++; $display("FAIL bp_stable: got %0d changes want 0", obs_stable_bad); end
    n_checks++; if (word_errs(b) != 0) begin n_errors++; $display("FAIL bp_words: got %0d bad words want 0", word_errs(b)); end
    n_checks++; if (obs_last_bad != 0) begin n_errors++; $display("FAIL bp_last: got %0d bad want 0", obs_last_bad); end
    n_checks++; if (obs_after_valid !== 1'b0) begin n_errors++; $display("FAIL bp_extra_word: got valid=%b want 0", obs_after_valid); end
    n_checks++; if (obs_after_cnt !== CNT_W'(m_cnt)) begin n_errors++; $display("FAIL bp_cnt: got %0d want %0d", obs_after_cnt, m_cnt); end
  endtask

  task automatic test_change_during_send();
    logic [BW-1:0] b;
    int exp;
    b = rand_bundle();
    set_bundle(0, b);
    u_if.req_valid = 3'b001;
    exp = pick(3'b001, m_last);
    collect(3, 0);
    u_if.req_valid = '0;
    m_last = exp; m_cnt = (m_cnt + 1) % (1 << CNT_W);
    n_checks++; if (obs_timeout || obs_src !== SW'(exp)) begin
      n_errors++; $display("FAIL chg_src: got %0d (timeout=%0d) want %0d", obs_src, obs_timeout, exp);
    end
    n_checks++; if (word_errs(b) != 0) begin
      n_errors++; $display("FAIL chg_words: got %0d bad words (word8 %h) want 0", word_errs(b), (obs_q.size() == WORDS) ? obs_q[WORDS-1] : 32'h0);
    end
    n_checks++; if (obs_stable_bad != 0) begin n_errors++; $display("FAIL chg_stable: got %0d changes want 0", obs_stable_bad); end
  endtask

  task automatic test_random();
    logic [BW-1:0]    pend[N_REQ];
    logic [N_REQ-1:0] pv;
    int exp, i;
    pv = '0;
    for (int r = 0; r < 16; r++) begin
      if (r < 10) begin
        for (int j = 0; j < N_REQ; j++)
          if (!pv[j] && $urandom_range(0, 1) == 1) begin
            pend[j] = rand_bundle(); set_bundle(j, pend[j]); pv[j] = 1'b1;
          end
        if (pv == '0) begin
          i = $urandom_range(0, N_REQ - 1);
          pend[i] = rand_bundle(); set_bundle(i, pend[i]); pv[i] = 1'b1;
        end
      end else if (pv == '0) begin
        break;
      end
      u_if.req_valid = pv;
      exp = pick(pv, m_last);
      collect(1, 1);
      m_last = exp; m_cnt = (m_cnt + 1) % (1 << CNT_W);
      pv[exp] = 1'b0;
      u_if.req_valid = pv;
      n_checks++; if (obs_timeout || obs_src !== SW'(exp)) begin
        n_errors++; $display("FAIL rand_src[%0d]: got %0d (timeout=%0d) want %0d", r, obs_src, obs_timeout, exp);
      end
      n_checks++; if (word_errs(pend[exp]) != 0 || obs_last_bad != 0 || obs_stable_bad != 0) begin
        n_errors++; $display("FAIL rand_words[%0d]: got %0d/%0d/%0d word/last/stable errors want 0", r, word_errs(pend[exp]), obs_last_bad, obs_stable_bad);
      end
      n_checks++; if (obs_after_cnt !== CNT_W'(m_cnt)) begin n_errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", r, obs_after_cnt, m_cnt); end
    end
    u_if.req_valid = '0;
  endtask

  task automatic test_reset_mid_bundle();
    logic [BW-1:0] b;
    int n, hs, bad;
    b = rand_bundle();
    set_bundle(2, b);
    u_if.req_valid = 3'b100;
    u_if.out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!u_if.out_valid && n < 40);
    n_checks++; if (u_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_start: got valid=%b want 1", u_if.out_valid); end
    u_if.req_valid = '0;
    hs = 0; n = 0;
    while (hs < 5 && n < 100) begin
      @(posedge clk); #1; n++;
      if (u_if.out_valid) hs++;
    end
    n_checks++; if (u_if.out_data !== word_of(b, 5)) begin
      n_errors++; $display("FAIL rmid_word5: got %h want %h", u_if.out_data, word_of(b, 5));
    end
    #3 reset = 1'b0;
    #1;
    n_checks++; if (u_if.out_valid !== 1'b0 || u_if.out_last !== 1'b0 || u_if.busy !== 1'b0) begin
      n_errors++; $display("FAIL rmid_drop: got valid=%b last=%b busy=%b want 0 0 0", u_if.out_valid, u_if.out_last, u_if.busy);
    end
    n_checks++; if (u_if.bundle_cnt !== '0) begin n_errors++; $display("FAIL rmid_cnt: got %0d want 0", u_if.bundle_cnt); end
    m_cnt = 0; m_last = N_REQ - 1;
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rmid_after: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_counter_wrap();
    logic [BW-1:0]    b[N_REQ];
    logic [N_REQ-1:0] m;
    int exp;
    for (int k = 0; k < 17; k++) begin
      m = (k == 0) ? 3'b111 : 3'b100;
      for (int j = 0; j < N_REQ; j++) begin
        b[j] = rand_bundle(); set_bundle(j, b[j]);
      end
      u_if.req_valid = m;
      exp = pick(m, m_last);
      collect(1, 0);
      u_if.req_valid = '0;
      m_last = exp; m_cnt = (m_cnt + 1) % (1 << CNT_W);
      n_checks++; if (obs_timeout || obs_src !== SW'(exp) || word_errs(b[exp]) != 0) begin
        n_errors++; $display("FAIL wrap_bundle[%0d]: got src %0d, %0d bad words want src %0d, 0", k, obs_src, word_errs(b[exp]), exp);
      end
      n_checks++; if (obs_after_cnt !== CNT_W'(m_cnt)) begin n_errors++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", k, obs_after_cnt, m_cnt); end
    end
    n_checks++; if (u_if.bundle_cnt !== 4'd1) begin n_errors++; $display("FAIL wrap_final: got %0d want 1", u_if.bundle_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_bundle();
    test_round_robin();
    test_backpressure();
    test_change_during_send();
    test_random();
    test_reset_mid_bundle();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
